// File: rtl/readout_sequencer.sv
// Row readout sequencer: select row, settle, convert under ADC handshake, release, next row.
// Optional conversion timeout is compiled in with `define READOUT_TIMEOUT_EN.
module readout_sequencer #(
  parameter int NUM_ROWS      = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int CONV_MAX      = 8,
  localparam int ROW_W        = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                adc_done,
  output logic [NUM_ROWS-1:0] nre,
  output logic                ADC_enable,
  output logic [ROW_W-1:0]    row_idx,
  output logic                busy,
  output logic                done,
  output logic                timeout
);

  // One phase counter serves both the settle wait and the conversion timeout.
  localparam int CNT_MAXV = (SETTLE_CYCLES > CONV_MAX) ? SETTLE_CYCLES : CONV_MAX;
  localparam int CNT_W    = $clog2(CNT_MAXV + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(NUM_ROWS - 1);
`ifdef READOUT_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(CONV_MAX - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    CONVERT,
    RELEASE,
    FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ROW_W-1:0]    row_idx_q, row_idx_d;
  logic [NUM_ROWS-1:0] nre_q, nre_d;
  logic                adc_enable_q, adc_enable_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                row_sel;
`ifdef READOUT_TIMEOUT_EN
  logic                timeout_q, timeout_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_idx_d = row_idx_q;
`ifdef READOUT_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = SELECT;
            row_idx_d = '0;
            cnt_d     = '0;
`ifdef READOUT_TIMEOUT_EN
            timeout_d = 1'b0;
`endif
          end
        end
        SELECT: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = CONVERT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        CONVERT: begin
          // A done flag on the final allowed cycle still wins over the timeout.
          if (adc_done) begin
            state_d = RELEASE;
`ifdef READOUT_TIMEOUT_EN
          end else if (cnt_q == CONV_LAST) begin
            state_d   = RELEASE;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
`endif
          end
        end
        RELEASE: begin
          if (row_idx_q == LAST_ROW) begin
            state_d = FINISH;
          end else begin
            state_d   = SELECT;
            row_idx_d = row_idx_q + ROW_W'(1);
            cnt_d     = '0;
          end
        end
        FINISH: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    nre_d        = '1;
    row_sel      = (state_d == SELECT) || (state_d == CONVERT);
    adc_enable_d = (state_d == CONVERT);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == FINISH);
    for (int i = 0; i < NUM_ROWS; i++) begin
      nre_d[i] = !(row_sel && (row_idx_d == ROW_W'(i)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      row_idx_q    <= '0;
      nre_q        <= '1;
      adc_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef READOUT_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_idx_q    <= row_idx_d;
      nre_q        <= nre_d;
      adc_enable_q <= adc_enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef READOUT_TIMEOUT_EN
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign nre        = nre_q;
  assign ADC_enable = adc_enable_q;
  assign row_idx    = row_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef READOUT_TIMEOUT_EN
  assign timeout    = timeout_q;
`else
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_readout_sequencer.sv
// Scoreboard bench for readout_sequencer: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_readout_sequencer;

  localparam int N = 2;
  localparam int S = 4;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         abort;
  logic         adc_done;
  logic [N-1:0] nre;
  logic         ADC_enable;
  logic [0:0]   row_idx;
  logic         busy;
  logic         done;
  logic         timeout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [N-1:0] nre;
    logic       adc;
    logic [0:0] row;
    logic       busy;
    logic       done;
    logic       tout;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  readout_sequencer #(
    .NUM_ROWS(N),
    .SETTLE_CYCLES(S),
    .CONV_MAX(C)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .adc_done(adc_done),
    .nre(nre),
    .ADC_enable(ADC_enable),
    .row_idx(row_idx),
    .busy(busy),
    .done(done),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs in frame cycle n when every row converts after k cycles.
  function automatic exp_t frame_exp(input int base, input int n, input int k,
                                     input bit tmode, input string nm);
    exp_t e;
    int   len;
    int   fin;
    int   r;
    int   off;
    len    = S + k + 1;
    fin    = N * len + 1;
    e.cyc  = base + n;
    e.name = nm;
    e.nre  = '1;
    e.adc  = 1'b0;
    e.busy = 1'b1;
    e.done = 1'b0;
    e.row  = 1'(N - 1);
    e.tout = tmode && (n >= S + k + 1);
    if (n > fin) begin
      e.busy = 1'b0;
    end else if (n == fin) begin
      e.done = 1'b1;
    end else begin
      r     = (n - 1) / len;
      off   = (n - 1) % len + 1;
      e.row = 1'(r);
      if (off <= S + k) e.nre[r] = 1'b0;
      e.adc = (off > S) && (off <= S + k);
    end
    return e;
  endfunction

  task automatic push_range(input int base, input int k, input bit tmode,
                            input string nm, input int from, input int to);
    for (int n = from; n <= to; n++) exp_q.push_back(frame_exp(base, n, k, tmode, nm));
  endtask

  task automatic push_idle(input int at, input logic [0:0] row, input logic tout,
                           input string nm);
    exp_t e;
    e.cyc  = at;
    e.nre  = '1;
    e.adc  = 1'b0;
    e.row  = row;
    e.busy = 1'b0;
    e.done = 1'b0;
    e.tout = tout;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic begin_frame(output int base);
    drain();
    @(negedge clk);
    base     = cyc;
    start    = 1'b1;
    adc_done = 1'b0;
    abort    = 1'b0;
  endtask

  // Bit n of each mask is the input value held during frame cycle n.
  task automatic drive(input int ncyc, input logic [63:0] adc_m,
                       input logic [63:0] start_m, input int abort_at);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      start    = start_m[n];
      adc_done = adc_m[n];
      abort    = (n == abort_at);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [N+4:0] got;
    logic [N+4:0] want;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL %s cycle %0d: check skipped, got none required one", e.name, e.cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e     = exp_q.pop_front();
      got   = {nre, ADC_enable, row_idx, busy, done, timeout};
      want  = {e.nre, e.adc, e.row, e.busy, e.done, e.tout};
      total = total + 1;
      if (got !== want) begin
        bad = bad + 1;
        $display("FAIL %s cycle %0d: {nre,adc,row,busy,done,tout} got %b required %b",
                 e.name, cyc, got, want);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    logic [63:0] am;
    logic [63:0] sm;

    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    adc_done = 1'b0;
    push_idle(1, 1'b0, 1'b0, "reset_values");
    push_idle(2, 1'b0, 1'b0, "reset_values");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Normal frame: adc_done in the third CONVERT cycle of each row.
    begin_frame(base);
    push_range(base, 3, 1'b0, "normal", 1, 19);
    am = '0; am[7] = 1'b1; am[15] = 1'b1;
    drive(19, am, '0, 0);

    // adc_done held high: single-cycle conversions.
    begin_frame(base);
    push_range(base, 1, 1'b0, "immediate", 1, 14);
    am = '0;
    for (int n = 1; n <= 14; n++) am[n] = 1'b1;
    drive(14, am, '0, 0);

    // start while busy and adc_done during SELECT are both ignored.
    begin_frame(base);
    push_range(base, 3, 1'b0, "ignored", 1, 20);
    am = '0; sm = '0;
    am[2] = 1'b1; am[3] = 1'b1; am[4] = 1'b1; am[7] = 1'b1;
    am[10] = 1'b1; am[11] = 1'b1; am[12] = 1'b1; am[15] = 1'b1;
    sm[3] = 1'b1; sm[17] = 1'b1;
    drive(20, am, sm, 0);

    // Abort beats a simultaneous adc_done in row 0 CONVERT.
    begin_frame(base);
    push_range(base, 3, 1'b0, "abort", 1, 6);
    for (int n = 7; n <= 9; n++) push_idle(base + n, 1'b0, 1'b0, "abort_idle");
    am = '0; am[6] = 1'b1;
    drive(9, am, '0, 6);

    begin_frame(base);
    push_range(base, 3, 1'b0, "abort_restart", 1, 19);
    am = '0; am[7] = 1'b1; am[15] = 1'b1;
    drive(19, am, '0, 0);

    // Async reset between edges during row 0 CONVERT.
    begin_frame(base);
    push_range(base, 3, 1'b0, "reset_mid", 1, 5);
    for (int n = 6; n <= 10; n++) push_idle(base + n, 1'b0, 1'b0, "reset_mid_idle");
    drive(5, '0, '0, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

`ifdef READOUT_TIMEOUT_EN
    // No adc_done at all: every conversion times out after C cycles.
    begin_frame(base);
    push_range(base, C, 1'b1, "timeout", 1, 28);
    drive(28, '0, '0, 0);

    begin_frame(base);
    push_range(base, 3, 1'b0, "timeout_clear", 1, 19);
    am = '0; am[7] = 1'b1; am[15] = 1'b1;
    drive(19, am, '0, 0);
`endif

    drain();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/readout_sequencer.md
# readout_sequencer

Sequences the row readout of the pixel array after an exposure completes. For each row it drives that row's active-low read-enable, waits a settle interval, then holds `ADC_enable` until the ADC reports conversion complete. It releases the row and moves to the next. It sits between `FSM_control` (which issues `start` on the falling edge of `expose`) and the array/ADC, replacing the fixed-delay row-read timing with a counted, handshaked sequence.

## Interface
- `NUM_ROWS`, 2: rows read per frame; ≥1.
- `SETTLE_CYCLES`, 4: cycles a row is selected before conversion starts; ≥1.
- `CONV_MAX`, 8: conversion timeout in cycles; used only with the macro below; ≥1.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to read a frame; sampled only in IDLE.
- `abort`  in  1  synchronous abort; returns to IDLE from any state.
- `adc_done`  in  1  ADC conversion complete; sampled only in CONVERT.
- `nre`  out  NUM_ROWS  active-low row read enables; bit i selects row i; `NRE_1`/`NRE_2` map to bits 0/1.
- `ADC_enable`  out  1  high while converting the selected row.
- `row_idx`  out  $clog2(NUM_ROWS) (min 1)  index of the row being read.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the last row has been released.
- `timeout`  out  1  sticky conversion-timeout flag.

## Operation
- States: IDLE, SELECT, CONVERT, RELEASE, FINISH. All outputs are registered Moore outputs.
- IDLE: `nre` all ones, `ADC_enable`=0, `busy`=0. When `start`=1, go to SELECT, set `row_idx`=0, clear the settle counter, and clear `timeout`.
- SELECT: `nre[row_idx]`=0 and the other bits are 1. Count SETTLE_CYCLES cycles, then go to CONVERT.
- CONVERT: `nre[row_idx]` stays 0 and `ADC_enable`=1. If `adc_done`=1, go to RELEASE. `adc_done` in the first CONVERT cycle counts.
- RELEASE: one cycle; `nre` all ones, `ADC_enable`=0.
  - If `row_idx`==NUM_ROWS-1, go to FINISH.
  - Otherwise increment `row_idx` and go to SELECT.
- FINISH: one cycle; `done`=1 and `nre` all ones; then go to IDLE. `row_idx` holds its last value until the next accepted start.
- Only one `nre` bit is ever low. `ADC_enable` is never high unless a row is selected.
- `start` while `busy`: ignored; no queuing.
- `adc_done` outside CONVERT: ignored.
- `abort`: takes priority over every transition, including a simultaneous `start` or `adc_done`.
  - Next state is IDLE with `nre` all ones and `ADC_enable`=0.
  - `done` is not pulsed; `timeout` is held.
- `reset` mid-frame: outputs go to reset values immediately. No `done` pulse.

## Timing
- Reset values: `nre` all ones, `ADC_enable`=0, `row_idx`=0, `busy`=0, `done`=0, `timeout`=0, state IDLE.
- Take `start` as sampled at edge 0, and `adc_done` as first seen in CONVERT cycle k (k≥1):
  - SELECT (`nre` low) is cycles 1..S; CONVERT is S+1..S+k; RELEASE is S+k+1.
  - Each row takes S+k+1 cycles. The next row's SELECT begins immediately after RELEASE.
  - `done` is high in cycle NUM_ROWS·(S+k+1)+1. `busy` falls in the cycle after that.
- Back-to-back frames: a `start` arriving during the FINISH cycle is ignored. The earliest accepted `start` is the first IDLE cycle.

## Configuration
- `READOUT_TIMEOUT_EN` defined: a conversion counter runs in CONVERT.
  - After CONV_MAX CONVERT cycles with no `adc_done`, go to RELEASE and set `timeout`=1.
  - `timeout` is sticky until the next accepted `start` or `reset`.
  - The sequence continues with the remaining rows, and `done` still pulses.
  - `adc_done` in cycle CONV_MAX counts as success.
- Not defined: CONVERT waits indefinitely for `adc_done`. The `timeout` port exists and is tied to 0.

## Test plan
- Normal frame: NUM_ROWS=2, S=4, `start` at edge 0, `adc_done` pulsed in the 3rd CONVERT cycle of each row.
  - `nre`=2'b10 in cycles 1–7 and 2'b01 in cycles 9–15.
  - `ADC_enable` high in cycles 5–7 and 13–15.
  - `done` high only in cycle 17; `busy` low from cycle 18.
- Immediate `adc_done` (held high throughout): each row takes 6 cycles; `done` in cycle 13; CONVERT lasts 1 cycle per row.
- Ignored inputs:
  - `start` pulsed in cycles 3 and 17 of a normal frame: no restart, no second frame.
  - `adc_done` high during SELECT: no early conversion.
- Abort: `abort` in the same cycle as `adc_done` during row 0 CONVERT.
  - Next cycle: IDLE, `nre`=all ones, `ADC_enable`=0, no `done`.
  - A new `start` then runs a full frame.
- Async reset asserted mid-CONVERT, between clock edges: outputs reach reset values without waiting for a clock edge; no `done` pulse.
- With `READOUT_TIMEOUT_EN`, CONV_MAX=8, `adc_done` never asserted:
  - Each CONVERT lasts exactly 8 cycles; `timeout`=1 from the first RELEASE.
  - `done` in cycle 27.
  - The next `start` clears `timeout`.
